// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings and default latencies for the MIPS32 pipeline control
// Purpose: FSM state encoding for the data-memory wait tracker, default mult/div/wait
//          parameters and the mult/div operation selector encoding.
// Ports:   none (package).
package mips_pkg;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MEMWAIT = 1'b1
    } mw_state_t;

    localparam int MULT_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF  = 32;
    localparam int WAIT_MAX_DEF    = 255;

    localparam logic MD_OP_MULT = 1'b0;
    localparam logic MD_OP_DIV  = 1'b1;

endpackage

// File: rtl/md_busy_counter.sv
// rtl/md_busy_counter.sv - mult/div occupancy counter producing busy and done
// Purpose: loads the EX-side mult or div latency on a start while idle and counts
//          down every cycle; busy while non-zero, done pulses for one cycle on 1->0.
// Ports:   clock, reset (sync, active-high), start, op (0=mult, 1=div),
//          busy (mult/div in flight), done (one-cycle pulse, HI/LO valid).
module md_busy_counter
    import mips_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic op,
    output logic busy,
    output logic done
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    logic [CW-1:0] md_cnt;

    assign busy = (md_cnt != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            md_cnt <= '0;
            done   <= 1'b0;
        end else begin
            // A count of 1 always expires on this edge, since loads only happen from 0.
            done <= (md_cnt == CW'(1));
            if (md_cnt == '0) begin
                // A start seen while busy cannot be issued legally and is dropped.
                if (start) begin
                    md_cnt <= (op == MD_OP_DIV) ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
                end
            end else begin
                md_cnt <= md_cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - stall/flush/bubble sequencer for the 5-stage MIPS32 pipeline
// Purpose: resolves load-use, HI/LO-use-while-busy, taken branch/jump flush and data-memory
//          wait-state hazards; tracks mult/div occupancy and a sticky memory timeout.
// Ports:   clock, reset (sync, active-high); hazard inputs from ID/EX/MEM stages;
//          stall/flush/bubble controls (combinational) for PC, IF/ID, ID/EX, EX/MEM, MEM/WB;
//          MulDivBusy, MulDivDone, MemTimeout (registered status).
module hazard_control_unit
    import mips_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int WAIT_MAX    = WAIT_MAX_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       IDEX_MemRead,
    input  logic [4:0] IDEX_RegRt,
    input  logic [4:0] IFID_RegRs,
    input  logic [4:0] IFID_RegRt,
    input  logic       ID_UsesRt,
    input  logic       ID_HiLoUse,
    input  logic       ID_Jump,
    input  logic       EX_BranchTaken,
    input  logic       EX_MulDivStart,
    input  logic       EX_MulDivOp,
    input  logic       MEM_Access,
    input  logic       DMem_Ready,
    output logic       PC_Stall,
    output logic       IFID_Stall,
    output logic       IFID_Flush,
    output logic       IDEX_Stall,
    output logic       IDEX_Flush,
    output logic       EXMEM_Stall,
    output logic       MEMWB_Bubble,
    output logic       MulDivBusy,
    output logic       MulDivDone,
    output logic       MemTimeout
);

    localparam int WC = $clog2(WAIT_MAX + 1);

    logic          freeze;
    logic          hilo;
    logic          loaduse;
    mw_state_t     state;
    logic [WC-1:0] wait_cnt;

    md_busy_counter #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md (
        .clock(clock),
        .reset(reset),
        .start(EX_MulDivStart),
        .op   (EX_MulDivOp),
        .busy (MulDivBusy),
        .done (MulDivDone)
    );

    assign freeze  = MEM_Access & ~DMem_Ready;
    assign hilo    = ID_HiLoUse & MulDivBusy;
    // Register $0 never carries a real dependency.
    assign loaduse = IDEX_MemRead & (IDEX_RegRt != 5'd0) &
                     ((IDEX_RegRt == IFID_RegRs) | (ID_UsesRt & (IDEX_RegRt == IFID_RegRt)));

    always_comb begin
        PC_Stall     = 1'b0;
        IFID_Stall   = 1'b0;
        IFID_Flush   = 1'b0;
        IDEX_Stall   = 1'b0;
        IDEX_Flush   = 1'b0;
        EXMEM_Stall  = 1'b0;
        MEMWB_Bubble = 1'b0;
        if (!reset) begin
            if (freeze) begin
                // Whole pipe holds; a pending branch/jump stays in its frozen register
                // and is acted on in the release cycle.
                PC_Stall     = 1'b1;
                IFID_Stall   = 1'b1;
                IDEX_Stall   = 1'b1;
                EXMEM_Stall  = 1'b1;
                MEMWB_Bubble = 1'b1;
            end else if (EX_BranchTaken) begin
                // Both younger instructions are wrong-path, so any stall on them is moot.
                IFID_Flush = 1'b1;
                IDEX_Flush = 1'b1;
            end else if (hilo || loaduse) begin
                PC_Stall   = 1'b1;
                IFID_Stall = 1'b1;
                IDEX_Flush = 1'b1;
            end else if (ID_Jump) begin
                IFID_Flush = 1'b1;
            end
        end
    end

    // wait_cnt counts consecutive frozen cycles, so it reads WAIT_MAX after that many.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_RUN;
            wait_cnt   <= '0;
            MemTimeout <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (freeze) begin
                        state    <= ST_MEMWAIT;
                        wait_cnt <= WC'(1);
                        if (WAIT_MAX == 1) MemTimeout <= 1'b1;
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                ST_MEMWAIT: begin
                    if (!freeze) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt != WC'(WAIT_MAX)) begin
                        wait_cnt <= wait_cnt + WC'(1);
                        if (wait_cnt == WC'(WAIT_MAX - 1)) MemTimeout <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - self-checking bench for hazard_control_unit
module tb_hazard_control_unit;

    localparam int MULT_CYCLES = 4;
    localparam int DIV_CYCLES  = 32;
    localparam int WAIT_MAX    = 255;

    localparam logic [6:0] V_NONE   = 7'b0000000;
    localparam logic [6:0] V_FREEZE = 7'b1101011;
    localparam logic [6:0] V_BRANCH = 7'b0010100;
    localparam logic [6:0] V_STALL  = 7'b1100100;
    localparam logic [6:0] V_JUMP   = 7'b0010000;

    logic       clock = 1'b0;
    logic       reset;
    logic       IDEX_MemRead;
    logic [4:0] IDEX_RegRt;
    logic [4:0] IFID_RegRs;
    logic [4:0] IFID_RegRt;
    logic       ID_UsesRt;
    logic       ID_HiLoUse;
    logic       ID_Jump;
    logic       EX_BranchTaken;
    logic       EX_MulDivStart;
    logic       EX_MulDivOp;
    logic       MEM_Access;
    logic       DMem_Ready;
    logic       PC_Stall, IFID_Stall, IFID_Flush, IDEX_Stall, IDEX_Flush;
    logic       EXMEM_Stall, MEMWB_Bubble, MulDivBusy, MulDivDone, MemTimeout;
    logic [6:0] ctrl;

    int checks   = 0;
    int failures = 0;

    // Reference model: mult/div occupancy as the cycle index where the result lands,
    // memory timeout as the length of the current run of frozen cycles.
    int cyc;
    int md_end;
    int run;
    bit m_timeout;

    hazard_control_unit #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .WAIT_MAX   (WAIT_MAX)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .IDEX_MemRead  (IDEX_MemRead),
        .IDEX_RegRt    (IDEX_RegRt),
        .IFID_RegRs    (IFID_RegRs),
        .IFID_RegRt    (IFID_RegRt),
        .ID_UsesRt     (ID_UsesRt),
        .ID_HiLoUse    (ID_HiLoUse),
        .ID_Jump       (ID_Jump),
        .EX_BranchTaken(EX_BranchTaken),
        .EX_MulDivStart(EX_MulDivStart),
        .EX_MulDivOp   (EX_MulDivOp),
        .MEM_Access    (MEM_Access),
        .DMem_Ready    (DMem_Ready),
        .PC_Stall      (PC_Stall),
        .IFID_Stall    (IFID_Stall),
        .IFID_Flush    (IFID_Flush),
        .IDEX_Stall    (IDEX_Stall),
        .IDEX_Flush    (IDEX_Flush),
        .EXMEM_Stall   (EXMEM_Stall),
        .MEMWB_Bubble  (MEMWB_Bubble),
        .MulDivBusy    (MulDivBusy),
        .MulDivDone    (MulDivDone),
        .MemTimeout    (MemTimeout)
    );

    assign ctrl = {PC_Stall, IFID_Stall, IFID_Flush, IDEX_Stall, IDEX_Flush, EXMEM_Stall, MEMWB_Bubble};

    always #5 clock = ~clock;

    function automatic bit m_busy();
        return cyc < md_end;
    endfunction

    function automatic bit m_done();
        return cyc == md_end;
    endfunction

    function automatic logic [6:0] exp_ctrl();
        bit frz, lu, hl;
        frz = MEM_Access && !DMem_Ready;
        hl  = ID_HiLoUse && m_busy();
        lu  = IDEX_MemRead && (IDEX_RegRt != 0) &&
              ((IDEX_RegRt == IFID_RegRs) || (ID_UsesRt && (IDEX_RegRt == IFID_RegRt)));
        if (reset)               return V_NONE;
        else if (frz)            return V_FREEZE;
        else if (EX_BranchTaken) return V_BRANCH;
        else if (hl || lu)       return V_STALL;
        else if (ID_Jump)        return V_JUMP;
        return V_NONE;
    endfunction

    task automatic tick();
        @(posedge clock);
        if (reset) begin
            cyc = 0; md_end = -1; run = 0; m_timeout = 0;
        end else begin
            if (EX_MulDivStart && !m_busy())
                md_end = cyc + (EX_MulDivOp ? DIV_CYCLES : MULT_CYCLES);
            if (MEM_Access && !DMem_Ready) run++; else run = 0;
            if (run >= WAIT_MAX) m_timeout = 1;
            cyc++;
        end
        #1;
    endtask

    task automatic idle_inputs();
        IDEX_MemRead = 0; IDEX_RegRt = 0; IFID_RegRs = 0; IFID_RegRt = 0;
        ID_UsesRt = 0; ID_HiLoUse = 0; ID_Jump = 0; EX_BranchTaken = 0;
        EX_MulDivStart = 0; EX_MulDivOp = 0; MEM_Access = 0; DMem_Ready = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        MEM_Access = 1; DMem_Ready = 0; EX_BranchTaken = 1; ID_Jump = 1;
        IDEX_MemRead = 1; IDEX_RegRt = 5; IFID_RegRs = 5;
        @(negedge clock);
        checks++;
        if (ctrl !== V_NONE) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, V_NONE);
        end
        tick();
        reset = 0;
        idle_inputs();
        @(negedge clock);
        checks++;
        if ({MulDivBusy, MulDivDone, MemTimeout} !== 3'b000) begin
            failures++; $display("FAIL reset_status got=%b exp=000", {MulDivBusy, MulDivDone, MemTimeout});
        end
        checks++;
        if (ctrl !== V_NONE) begin
            failures++; $display("FAIL reset_idle_ctrl got=%b exp=%b", ctrl, V_NONE);
        end
        tick();
    endtask

    task automatic test_load_use();
        idle_inputs();
        IDEX_MemRead = 1; IDEX_RegRt = 5; IFID_RegRs = 5; IFID_RegRt = 7;
        @(negedge clock);
        checks++;
        if (ctrl !== V_STALL) begin
            failures++; $display("FAIL loaduse_rs got=%b exp=%b", ctrl, V_STALL);
        end
        tick();
        IDEX_MemRead = 0; IDEX_RegRt = 0;
        @(negedge clock);
        checks++;
        if (ctrl !== V_NONE) begin
            failures++; $display("FAIL loaduse_bubble got=%b exp=%b", ctrl, V_NONE);
        end
        tick();
        IDEX_MemRead = 1; IDEX_RegRt = 0; IFID_RegRs = 0; IFID_RegRt = 0; ID_UsesRt = 1;
        @(negedge clock);
        checks++;
        if (ctrl !== V_NONE) begin
            failures++; $display("FAIL loaduse_r0 got=%b exp=%b", ctrl, V_NONE);
        end
        tick();
        IDEX_RegRt = 5; IFID_RegRs = 3; IFID_RegRt = 5; ID_UsesRt = 0;
        @(negedge clock);
        checks++;
        if (ctrl !== V_NONE) begin
            failures++; $display("FAIL loaduse_rt_unused got=%b exp=%b", ctrl, V_NONE);
        end
        ID_UsesRt = 1;
        #1;
        checks++;
        if (ctrl !== V_STALL) begin
            failures++; $display("FAIL loaduse_rt_used got=%b exp=%b", ctrl, V_STALL);
        end
        tick();
        idle_inputs();
    endtask

    task automatic run_md(input logic op, input int lat, input string name);
        int bad;
        idle_inputs();
        EX_MulDivStart = 1; EX_MulDivOp = op;
        tick();
        EX_MulDivStart = 0; ID_HiLoUse = 1;
        bad = 0;
        for (int i = 0; i < lat - 1; i++) begin
            @(negedge clock);
            if (ctrl !== V_STALL || MulDivBusy !== 1'b1 || MulDivDone !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL %s_stall_window bad_cycles=%0d exp=0", name, bad);
        end
        @(negedge clock);
        checks++;
        if ({ctrl, MulDivBusy, MulDivDone} !== {V_NONE, 2'b01}) begin
            failures++; $display("FAIL %s_release got=%b exp=%b", name, {ctrl, MulDivBusy, MulDivDone}, {V_NONE, 2'b01});
        end
        tick();
        @(negedge clock);
        checks++;
        if (MulDivDone !== 1'b0) begin
            failures++; $display("FAIL %s_done_pulse got=%b exp=0", name, MulDivDone);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_div_hilo();
        run_md(1'b1, DIV_CYCLES, "div");
        run_md(1'b0, MULT_CYCLES, "mult");
    endtask

    task automatic test_freeze_branch();
        int bad;
        idle_inputs();
        MEM_Access = 1; DMem_Ready = 0; EX_BranchTaken = 1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (ctrl !== V_FREEZE) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL freeze_branch_hold bad_cycles=%0d exp=0", bad);
        end
        DMem_Ready = 1;
        @(negedge clock);
        checks++;
        if (ctrl !== V_BRANCH) begin
            failures++; $display("FAIL freeze_release_flush got=%b exp=%b", ctrl, V_BRANCH);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_loaduse_branch();
        idle_inputs();
        IDEX_MemRead = 1; IDEX_RegRt = 9; IFID_RegRs = 9; EX_BranchTaken = 1;
        @(negedge clock);
        checks++;
        if (ctrl !== V_BRANCH) begin
            failures++; $display("FAIL loaduse_branch got=%b exp=%b", ctrl, V_BRANCH);
        end
        EX_BranchTaken = 0; ID_Jump = 1;
        #1;
        checks++;
        if (ctrl !== V_STALL) begin
            failures++; $display("FAIL loaduse_over_jump got=%b exp=%b", ctrl, V_STALL);
        end
        IDEX_MemRead = 0;
        #1;
        checks++;
        if (ctrl !== V_JUMP) begin
            failures++; $display("FAIL jump_only got=%b exp=%b", ctrl, V_JUMP);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        logic [6:0] e;
        for (int i = 0; i < 600; i++) begin
            reset          = ($urandom_range(0, 99) == 0);
            IDEX_MemRead   = $urandom_range(0, 1);
            IDEX_RegRt     = 5'($urandom_range(0, 3));
            IFID_RegRs     = 5'($urandom_range(0, 3));
            IFID_RegRt     = 5'($urandom_range(0, 3));
            ID_UsesRt      = $urandom_range(0, 1);
            ID_HiLoUse     = $urandom_range(0, 1);
            ID_Jump        = ($urandom_range(0, 3) == 0);
            EX_BranchTaken = ($urandom_range(0, 5) == 0);
            EX_MulDivStart = ($urandom_range(0, 7) == 0);
            EX_MulDivOp    = ($urandom_range(0, 3) == 0);
            MEM_Access     = ($urandom_range(0, 2) == 0);
            DMem_Ready     = $urandom_range(0, 1);
            @(negedge clock);
            e = exp_ctrl();
            checks++;
            if (ctrl !== e) begin
                failures++; $display("FAIL rand_ctrl cyc=%0d got=%b exp=%b", i, ctrl, e);
            end
            checks++;
            if ({MulDivBusy, MulDivDone, MemTimeout} !== {m_busy(), m_done(), m_timeout}) begin
                failures++;
                $display("FAIL rand_status cyc=%0d got=%b exp=%b", i,
                         {MulDivBusy, MulDivDone, MemTimeout}, {m_busy(), m_done(), m_timeout});
            end
            tick();
        end
        reset = 0;
        idle_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        MEM_Access = 1; DMem_Ready = 0;
        for (int i = 0; i < WAIT_MAX; i++) begin
            if (i == WAIT_MAX - 1) begin
                @(negedge clock);
                checks++;
                if ({ctrl, MemTimeout} !== {V_FREEZE, 1'b0}) begin
                    failures++; $display("FAIL timeout_early got=%b exp=%b", {ctrl, MemTimeout}, {V_FREEZE, 1'b0});
                end
            end
            tick();
        end
        @(negedge clock);
        checks++;
        if (MemTimeout !== 1'b1) begin
            failures++; $display("FAIL timeout_set got=%b exp=1", MemTimeout);
        end
        checks++;
        if (ctrl !== V_FREEZE) begin
            failures++; $display("FAIL timeout_freeze got=%b exp=%b", ctrl, V_FREEZE);
        end
        DMem_Ready = 1;
        for (int i = 0; i < 5; i++) tick();
        idle_inputs();
        @(negedge clock);
        checks++;
        if ({ctrl, MemTimeout} !== {V_NONE, 1'b1}) begin
            failures++; $display("FAIL timeout_sticky got=%b exp=%b", {ctrl, MemTimeout}, {V_NONE, 1'b1});
        end
        do_reset();
        @(negedge clock);
        checks++;
        if (MemTimeout !== 1'b0) begin
            failures++; $display("FAIL timeout_reset got=%b exp=0", MemTimeout);
        end
        MEM_Access = 1; DMem_Ready = 0;
        for (int i = 0; i < 10; i++) tick();
        idle_inputs();
        tick();
        @(negedge clock);
        checks++;
        if (MemTimeout !== 1'b0) begin
            failures++; $display("FAIL timeout_short_wait got=%b exp=0", MemTimeout);
        end
    endtask

    task automatic test_reset_midop();
        int pulses;
        idle_inputs();
        EX_MulDivStart = 1; EX_MulDivOp = 1;
        tick();
        EX_MulDivStart = 0;
        for (int i = 0; i < 5; i++) tick();
        @(negedge clock);
        checks++;
        if (MulDivBusy !== 1'b1) begin
            failures++; $display("FAIL midop_busy got=%b exp=1", MulDivBusy);
        end
        reset = 1; MEM_Access = 1; DMem_Ready = 0; ID_HiLoUse = 1;
        #1;
        checks++;
        if (ctrl !== V_NONE) begin
            failures++; $display("FAIL midop_reset_ctrl got=%b exp=%b", ctrl, V_NONE);
        end
        tick();
        reset = 0;
        idle_inputs();
        ID_HiLoUse = 1;
        pulses = 0;
        @(negedge clock);
        checks++;
        if ({ctrl, MulDivBusy} !== {V_NONE, 1'b0}) begin
            failures++; $display("FAIL midop_abandon got=%b exp=%b", {ctrl, MulDivBusy}, {V_NONE, 1'b0});
        end
        for (int i = 0; i < DIV_CYCLES + 4; i++) begin
            @(negedge clock);
            if (MulDivDone === 1'b1 || MulDivBusy === 1'b1) pulses++;
            tick();
        end
        checks++;
        if (pulses != 0) begin
            failures++; $display("FAIL midop_no_done got=%0d exp=0", pulses);
        end
        idle_inputs();
    endtask

    initial begin
        cyc = 0; md_end = -1; run = 0; m_timeout = 0;
        reset = 1;
        idle_inputs();
        #1;
        test_reset();
        test_load_use();
        test_div_hilo();
        test_freeze_branch();
        test_loaduse_branch();
        test_random();
        test_timeout();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
